display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexes NDIG digit values onto one shared 7-segment decoder instance (the existing display module, or the adder_display path).
- Per step, it selects one digit value, blanks all digits for a dead time, then enables that digit's anode for a fixed on-time.
- New digit data is accepted through a load/ready handshake and committed only at a frame boundary, so no digit ever shows a torn value.
- Sits between the datapath producing digit values and the physical display pins.

Parameters:
NDIG, 4, number of multiplexed digits (>=2)
DW, 2, bits per digit value; matches the shared decoder's input width
PRESCALE, 50000, clk cycles each digit's anode is on (>=1)
DEAD, 8, clk cycles all anodes are off before each digit (>=0; 0 skips the dead phase)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
en  in  1  1 = scanning, 0 = display off
load  in  1  request to capture data_in; accepted when load && ready
data_in  in  NDIG*DW  digit values; digit i = data_in[i*DW +: DW]
ready  out  1  1 = no pending update, load is accepted
digit_val  out  DW  value routed to the shared decoder inputs
an  out  NDIG  anode enables, active-low, one-hot-low or all ones
frame_tick  out  1  one-cycle pulse at the end of the last digit's on-time

Behaviour:
- All outputs are registered. Reset (rst_n=0 at a clk edge) values:
  - state=OFF, an=all ones, digit_val=0, ready=1, frame_tick=0.
  - Internal: idx=0, cnt=0, shadow=0, pending buffer=0, pend=0.
- FSM states: OFF, DEAD, ON.
  - OFF: an=all ones; idx=0, cnt=0.
    - en=1 -> DEAD, or -> ON if DEAD=0.
  - DEAD: an=all ones; digit_val=shadow[idx].
    - cnt counts 0..DEAD-1, then -> ON with cnt=0.
  - ON: an[idx]=0, others 1; digit_val=shadow[idx].
    - cnt counts 0..PRESCALE-1.
    - At terminal count with idx<NDIG-1: idx+1, cnt=0, -> DEAD (or ON if DEAD=0).
    - At terminal count with idx=NDIG-1: idx=0, frame_tick=1 for one cycle, commit (below), -> DEAD/ON.
  - en=0 in any state: -> OFF next cycle; an=all ones from that edge. Re-enable always restarts at digit 0 with a full dead phase.
- digit_val updates on the same edge as idx, i.e. while anodes are off when DEAD>0.
- Handshake:
  - load && ready: data_in is captured into the pending buffer, pend=1, ready=0 next cycle.
  - load while ready=0 is ignored; no queueing, the data is dropped.
- Commit, when pend=1: shadow<=pending buffer, pend=0, ready=1.
  - Occurs at the frame boundary edge.
  - In state OFF, occurs on the cycle after capture; latency 1 cycle, ready high again 2 cycles after the load edge.
- Simultaneous load && ready at the frame-boundary edge: the capture happens this edge, and the commit waits for the next frame boundary.
- Counter width is clog2(max(PRESCALE,DEAD,2)). Terminal compare is against PRESCALE-1 or DEAD-1 exactly; no wrap beyond.
- Frame length is NDIG*(DEAD+PRESCALE) cycles.
- Reset mid-frame or mid-handshake: everything returns to reset values, and the pending data is discarded.

Decomposition:
- Shared include file (display_scan_defs.vh): state encodings OFF=2'd0, DEAD=2'd1, ON=2'd2, plus a clog2 helper function.
- One natural sub-module, scan_timer.
  - Loadable down/up counter with terminal-count output.
  - Instantiated once; its terminal value is selected by state.
- Digit select mux and handshake logic stay in the top.

Test Plan:
Bench parameters: NDIG=4, DW=2, PRESCALE=4, DEAD=1.
1. Reset then en=1, load data_in=8'b11_10_01_00 while OFF -> ready low 1 cycle then high; scan shows an=1111 for 1 cycle, then 1110 for 4 cycles with digit_val=0, then 1111, then 1101 with digit_val=1, and so on; frame_tick pulses every 20 cycles.
2. Mid-frame load of 8'hFF during digit 1 -> digits 1..3 keep old values for the rest of the frame; ready=0 until the frame_tick edge; the next frame shows digit_val=3 on all digits.
3. Second load while ready=0 with 8'h00 -> ignored; the first pending value is committed, not 8'h00.
4. en dropped during the ON phase of digit 2 -> an=1111 the next cycle and stays there; en re-raised -> restart at digit 0 after 1 dead cycle.
5. rst_n=0 for 1 cycle mid-frame with pend=1 -> all outputs return to reset values, and the old pending data is never displayed.
6. DEAD=0 build -> an is never all ones while en=1; each digit is active for exactly 4 cycles; frame_tick period is 16.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg: scan FSM state encodings and width helper shared by the scan controller.
package display_scan_ctrl_pkg;
  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_DEAD = 2'd1,
    S_ON   = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: digit load handshake and display pin bundle between datapath and scan controller.
interface display_scan_ctrl_if #(
  parameter int NDIG = 4,
  parameter int DW   = 2
);
  logic              en;
  logic              load;
  logic [NDIG*DW-1:0] data_in;
  logic              ready;
  logic [DW-1:0]     digit_val;
  logic [NDIG-1:0]   an;
  logic              frame_tick;

  modport master (output en, load, data_in, input ready, digit_val, an, frame_tick);
  modport slave  (input en, load, data_in, output ready, digit_val, an, frame_tick);
endinterface

// File: rtl/display_scan_ctrl_scan_timer.sv
// scan_timer: phase counter cleared on load, flags when it reaches the selected terminal value.
module scan_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic [CW-1:0] i_term,
  output logic          o_tc
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) r_cnt <= '0;
    else r_cnt <= r_cnt + CW'(1);
  end

  assign o_tc = r_cnt == i_term;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexes NDIG digits onto one shared decoder with dead time
// and frame-boundary commit of newly loaded digit data.
module display_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int DW       = 2,
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 8
) (
  input logic          clk,
  input logic          rst_n,
  display_scan_ctrl_if.slave bus
);
  import display_scan_ctrl_pkg::*;

  localparam int IW = clog2(NDIG);
  localparam int MX = PRESCALE > DEAD ? PRESCALE : DEAD;
  localparam int CW = clog2(MX > 2 ? MX : 2);
  localparam logic [CW-1:0] T_ON   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] T_DEAD = CW'(DEAD > 0 ? DEAD - 1 : 0);
  localparam state_t S_RUN = (DEAD == 0) ? S_ON : S_DEAD;

  state_t             r_state, w_next;
  logic [IW-1:0]      r_idx, w_idx;
  logic [NDIG*DW-1:0] r_shadow, r_buf, w_shadow;
  logic [NDIG-1:0]    r_an;
  logic [DW-1:0]      r_dv;
  logic               r_pend, r_ready, r_ft;
  logic               w_pend, w_tc, w_last, w_frame, w_commit, w_cap, w_clr;

  scan_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_term(r_state == S_ON ? T_ON : T_DEAD),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_next   = r_state;
    w_idx    = r_idx;
    w_last   = r_idx == IW'(NDIG - 1);
    w_frame  = bus.en && r_state == S_ON && w_tc && w_last;
    if (!bus.en) begin
      w_next = S_OFF;
      w_idx  = '0;
    end else if (r_state == S_OFF) begin
      w_next = S_RUN;
      w_idx  = '0;
    end else if (w_tc) begin
      w_next = (r_state == S_DEAD) ? S_ON : S_RUN;
      w_idx  = (r_state == S_ON) ? (w_last ? '0 : r_idx + IW'(1)) : r_idx;
    end
    // Pending data lands only at a frame edge, or immediately while the display is off
    w_cap    = bus.load && r_ready;
    w_commit = r_pend && (r_state == S_OFF || w_frame);
    w_pend   = w_cap || (r_pend && !w_commit);
    w_shadow = w_commit ? r_buf : r_shadow;
    w_clr    = !bus.en || r_state == S_OFF || w_tc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_OFF;
    else r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_shadow <= '0;
      r_buf    <= '0;
      r_pend   <= 1'b0;
      r_ready  <= 1'b1;
      r_ft     <= 1'b0;
      r_an     <= '1;
      r_dv     <= '0;
    end else begin
      r_idx    <= w_idx;
      r_shadow <= w_shadow;
      r_buf    <= w_cap ? bus.data_in : r_buf;
      r_pend   <= w_pend;
      r_ready  <= !w_pend;
      r_ft     <= w_frame;
      r_an     <= (w_next == S_ON) ? ~(NDIG'(1) << w_idx) : '1;
      r_dv     <= w_shadow[w_idx*DW +: DW];
    end
  end

  assign bus.ready      = r_ready;
  assign bus.digit_val  = r_dv;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_ft;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed checks of scan timing, frame commit, handshake drop, reset and DEAD=0 build.
module tb_display_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  display_scan_ctrl_if #(.NDIG(4), .DW(2)) ifa (), ifb ();

  display_scan_ctrl #(.NDIG(4), .DW(2), .PRESCALE(4), .DEAD(1)) u_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  display_scan_ctrl #(.NDIG(4), .DW(2), .PRESCALE(4), .DEAD(0)) u_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected scan outputs c cycles after the OFF->run edge, PRESCALE=4, NDIG=4
  task automatic chk_scan(input string tag, input int c, input int dead, input logic [7:0] data,
                          input logic [3:0] an, input logic [1:0] dv, input logic ft);
    int p, ph, d;
    logic [3:0] ean;
    p   = dead + 4;
    ph  = c % p;
    d   = (c / p) % 4;
    ean = (ph < dead) ? 4'hF : ~(4'b0001 << d);
    chk($sformatf("%s an c=%0d", tag, c), an, ean);
    chk($sformatf("%s digit_val c=%0d", tag, c), dv, data[d*2 +: 2]);
    chk($sformatf("%s frame_tick c=%0d", tag, c), ft, (c > 0 && c % (4 * p) == 0) ? 1 : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    ifa.en = 0; ifa.load = 0; ifa.data_in = 0;
    ifb.en = 0; ifb.load = 0; ifb.data_in = 0;
    tick(2);
    chk("rst an", ifa.an, 4'hF);
    chk("rst digit_val", ifa.digit_val, 0);
    chk("rst ready", ifa.ready, 1);
    chk("rst frame_tick", ifa.frame_tick, 0);
    chk("rst b an", ifb.an, 4'hF);
    rst_n = 1;
    ifa.load = 1; ifa.data_in = 8'b11_10_01_00;
    tick;
    ifa.load = 0;
    chk("off load ready low", ifa.ready, 0);
    tick;
    chk("off commit ready high", ifa.ready, 1);
    chk("off an", ifa.an, 4'hF);
    ifa.en = 1;
    tick;
    for (int c = 0; c <= 72; c++) begin
      chk_scan("A", c, 1, c < 40 ? 8'hE4 : 8'hFF, ifa.an, ifa.digit_val, ifa.frame_tick);
      chk($sformatf("A ready c=%0d", c), ifa.ready, (c >= 27 && c < 40) ? 0 : 1);
      ifa.load = (c == 26 || c == 27);
      ifa.data_in = (c == 26) ? 8'hFF : 8'h00;
      if (c == 72) ifa.en = 0;
      tick;
    end
    chk("en off an", ifa.an, 4'hF);
    chk("en off frame_tick", ifa.frame_tick, 0);
    tick(3);
    chk("en off hold an", ifa.an, 4'hF);
    ifa.en = 1;
    tick;
    chk("restart dead an", ifa.an, 4'hF);
    tick;
    chk("restart d0 an", ifa.an, 4'hE);
    chk("restart d0 digit_val", ifa.digit_val, 3);
    tick(5);
    chk("pre-rst d1 an", ifa.an, 4'hD);
    ifa.load = 1; ifa.data_in = 8'b01_10_11_01;
    tick;
    ifa.load = 0;
    chk("pre-rst ready low", ifa.ready, 0);
    rst_n = 0;
    tick;
    chk("mid rst an", ifa.an, 4'hF);
    chk("mid rst digit_val", ifa.digit_val, 0);
    chk("mid rst ready", ifa.ready, 1);
    chk("mid rst frame_tick", ifa.frame_tick, 0);
    rst_n = 1;
    tick;
    for (int c = 0; c <= 20; c++) begin
      chk_scan("A post-rst", c, 1, 8'h00, ifa.an, ifa.digit_val, ifa.frame_tick);
      chk($sformatf("A post-rst ready c=%0d", c), ifa.ready, 1);
      tick;
    end
    ifb.load = 1; ifb.data_in = 8'b00_01_10_11;
    tick;
    ifb.load = 0;
    chk("B load ready low", ifb.ready, 0);
    tick;
    chk("B commit ready high", ifb.ready, 1);
    ifb.en = 1;
    tick;
    for (int c = 0; c <= 32; c++) begin
      chk_scan("B", c, 0, 8'h1B, ifb.an, ifb.digit_val, ifb.frame_tick);
      tick;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
